// File: rtl/instruction_dispatcher.sv
// -----------------------------------------------------------------------------
// instruction_dispatcher
//
// Purpose:
//   Feeds the register-management stage of the dual-core MCU. It takes one
//   decoded instruction at a time, stalls while any register it touches is
//   still marked busy in processing_register_table, then picks a core. It
//   issues the boot_renew_* pulse and register_num that the manager consumes,
//   and it starts the chosen core. Barrier (sync) instructions do not boot
//   anything. They hold the dispatcher until both cores are idle and the
//   manager reports them synchronized.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   instr_valid/instr_ready    upstream handshake (see below)
//   instr_data                 instruction payload
//   instr_dst                  destination registers {d3,d2,d1}
//   instr_src                  source registers {s2,s1}
//   instr_multi                3-destination instruction (core 2 only)
//   instr_barrier              sync instruction
//   processing_register_table  busy register flags from the manager
//   processor_idle_1/2         core idle flags
//   synchronized_processors    manager: both cores synchronized
//   boot_renew_register_1/2    single-destination boot pulse
//   boot_renew_3registers_1/2  three-destination boot pulse (_1 never used)
//   register_num               {d3,d2,d1} of the booted instruction
//   core_start_1/2             one-cycle core start, aligned with the boot pulse
//   core_instr                 payload of the most recently booted instruction
//   dispatch_error             sticky flag: a core never acknowledged a start
//   issued_count               number of booted instructions (wraps)
//   state_dbg                  current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where instr_valid and
// instr_ready are both high. The producer holds its payload stable while
// instr_valid is high and instr_ready is low. instr_ready is registered and
// is high only while the dispatcher is idle.
// -----------------------------------------------------------------------------
module instruction_dispatcher #(
    parameter int REGISTER_AMOUNT = 32,
    parameter int INSTR_WIDTH     = 32,
    parameter int ACK_TIMEOUT     = 255,
    parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [INSTR_WIDTH-1:0]       instr_data,
    input  logic [3*REG_CTN_WIDTH-1:0]   instr_dst,
    input  logic [2*REG_CTN_WIDTH-1:0]   instr_src,
    input  logic                         instr_multi,
    input  logic                         instr_barrier,
    input  logic [0:REGISTER_AMOUNT-1]   processing_register_table,
    input  logic                         processor_idle_1,
    input  logic                         processor_idle_2,
    input  logic                         synchronized_processors,
    output logic                         boot_renew_register_1,
    output logic                         boot_renew_register_2,
    output logic                         boot_renew_3registers_1,
    output logic                         boot_renew_3registers_2,
    output logic [3*REG_CTN_WIDTH-1:0]   register_num,
    output logic                         core_start_1,
    output logic                         core_start_2,
    output logic [INSTR_WIDTH-1:0]       core_instr,
    output logic                         dispatch_error,
    output logic [15:0]                  issued_count,
    output logic [1:0]                   state_dbg
);

    localparam int ACK_CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam int RW        = REG_CTN_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CHECK    = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_SYNC     = 2'd3
    } state_t;

    state_t                   state;
    logic [INSTR_WIDTH-1:0]   data_q;
    logic [3*RW-1:0]          dst_q;
    logic [2*RW-1:0]          src_q;
    logic                     multi_q;
    logic                     target_2_q;   // 0: core 1 booted, 1: core 2 booted
    logic [ACK_CNT_W-1:0]     ack_cnt;

    logic                     hazard;
    logic                     go_1;
    logic                     go_2;
    logic                     target_idle;

    // Register 0 is hard-wired and never tracked by the manager.
    function automatic logic reg_busy(input logic [RW-1:0] idx);
        return (idx != '0) && processing_register_table[idx];
    endfunction

    always_comb begin
        hazard = reg_busy(src_q[RW-1:0]) | reg_busy(src_q[2*RW-1:RW]) |
                 reg_busy(dst_q[RW-1:0]);
        if (multi_q) begin
            hazard = hazard | reg_busy(dst_q[2*RW-1:RW]) | reg_busy(dst_q[3*RW-1:2*RW]);
        end
    end

    // Core 2 is the only core that accepts 3-destination instructions.
    // Single-destination instructions prefer core 1.
    always_comb begin
        go_1 = 1'b0;
        go_2 = 1'b0;
        if (!hazard) begin
            if (multi_q) begin
                go_2 = processor_idle_2;
            end else if (processor_idle_1) begin
                go_1 = 1'b1;
            end else begin
                go_2 = processor_idle_2;
            end
        end
    end

    assign target_idle             = target_2_q ? processor_idle_2 : processor_idle_1;
    assign boot_renew_3registers_1 = 1'b0;
    assign state_dbg               = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                   <= S_IDLE;
            instr_ready             <= 1'b1;
            data_q                  <= '0;
            dst_q                   <= '0;
            src_q                   <= '0;
            multi_q                 <= 1'b0;
            target_2_q              <= 1'b0;
            ack_cnt                 <= '0;
            boot_renew_register_1   <= 1'b0;
            boot_renew_register_2   <= 1'b0;
            boot_renew_3registers_2 <= 1'b0;
            register_num            <= '0;
            core_start_1            <= 1'b0;
            core_start_2            <= 1'b0;
            core_instr              <= '0;
            dispatch_error          <= 1'b0;
            issued_count            <= '0;
        end else begin
            // Boot and start pulses last exactly one cycle.
            boot_renew_register_1   <= 1'b0;
            boot_renew_register_2   <= 1'b0;
            boot_renew_3registers_2 <= 1'b0;
            core_start_1            <= 1'b0;
            core_start_2            <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        data_q      <= instr_data;
                        dst_q       <= instr_dst;
                        src_q       <= instr_src;
                        multi_q     <= instr_multi;
                        instr_ready <= 1'b0;
                        state       <= instr_barrier ? S_SYNC : S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (go_1 || go_2) begin
                        boot_renew_register_1   <= go_1;
                        boot_renew_register_2   <= go_2 && !multi_q;
                        boot_renew_3registers_2 <= go_2 && multi_q;
                        core_start_1            <= go_1;
                        core_start_2            <= go_2;
                        core_instr              <= data_q;
                        register_num            <= multi_q ? dst_q : {{(2*RW){1'b0}}, dst_q[RW-1:0]};
                        issued_count            <= issued_count + 16'd1;
                        target_2_q              <= go_2;
                        ack_cnt                 <= '0;
                        state                   <= S_WAIT_ACK;
                    end
                end

                // The first cycle here coincides with the boot pulse. That cycle
                // lets the manager's table update land before the next check.
                S_WAIT_ACK: begin
                    if (!target_idle) begin
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end else if (ack_cnt == ACK_CNT_W'(ACK_TIMEOUT - 1)) begin
                        dispatch_error <= 1'b1;
                        instr_ready    <= 1'b1;
                        state          <= S_IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end

                S_SYNC: begin
                    if (synchronized_processors && processor_idle_1 && processor_idle_2) begin
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_instruction_dispatcher
//
// Purpose:
//   Self-checking bench for instruction_dispatcher. It runs directed scenarios
//   with literal expectations, followed by a randomized phase. A
//   transaction-level reference model and a boot scoreboard are checked
//   against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_instruction_dispatcher;

    localparam int RA = 32;
    localparam int IW = 32;
    localparam int AT = 255;
    localparam int RW = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [IW-1:0] instr_data = '0;
    logic [3*RW-1:0] instr_dst = '0;
    logic [2*RW-1:0] instr_src = '0;
    logic          instr_multi = 1'b0;
    logic          instr_barrier = 1'b0;
    logic [0:RA-1] reg_table = '0;
    logic          processor_idle_1;
    logic          processor_idle_2;
    logic          sync_proc = 1'b1;
    logic          boot_renew_register_1, boot_renew_register_2;
    logic          boot_renew_3registers_1, boot_renew_3registers_2;
    logic [3*RW-1:0] register_num;
    logic          core_start_1, core_start_2;
    logic [IW-1:0] core_instr;
    logic          dispatch_error;
    logic [15:0]   issued_count;
    logic [1:0]    state_dbg;

    instruction_dispatcher #(
        .REGISTER_AMOUNT(RA), .INSTR_WIDTH(IW), .ACK_TIMEOUT(AT)
    ) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_dst(instr_dst), .instr_src(instr_src),
        .instr_multi(instr_multi), .instr_barrier(instr_barrier),
        .processing_register_table(reg_table),
        .processor_idle_1(processor_idle_1), .processor_idle_2(processor_idle_2),
        .synchronized_processors(sync_proc),
        .boot_renew_register_1(boot_renew_register_1),
        .boot_renew_register_2(boot_renew_register_2),
        .boot_renew_3registers_1(boot_renew_3registers_1),
        .boot_renew_3registers_2(boot_renew_3registers_2),
        .register_num(register_num),
        .core_start_1(core_start_1), .core_start_2(core_start_2),
        .core_instr(core_instr), .dispatch_error(dispatch_error),
        .issued_count(issued_count), .state_dbg(state_dbg)
    );

    // ---------------- simple core emulation ----------------
    // A started core goes busy for a few cycles. force_x can hold a core non-idle.
    logic emu_en = 1'b1;
    logic force_1 = 1'b1;
    logic force_2 = 1'b1;
    int   busy1 = 0;
    int   busy2 = 0;
    assign processor_idle_1 = force_1 && (busy1 == 0);
    assign processor_idle_2 = force_2 && (busy2 == 0);

    always @(posedge clk) begin
        #1;
        if (rst) begin
            busy1 = 0;
            busy2 = 0;
        end else begin
            if (emu_en && core_start_1) busy1 = $urandom_range(1, 6);
            else if (busy1 != 0) busy1 = busy1 - 1;
            if (emu_en && core_start_2) busy2 = $urandom_range(1, 6);
            else if (busy2 != 0) busy2 = busy2 - 1;
        end
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the one instruction in flight by its capture data and boot time.
    // Expected outputs are derived from the hazard/target/ack rules.
    bit            model_live = 0;
    bit            inflight = 0;
    bit            booted = 0;
    int            t_boot = 0;
    int            tgt = 0;
    logic [IW-1:0] m_data;
    logic [3*RW-1:0] m_dst;
    logic [2*RW-1:0] m_src;
    bit            m_multi, m_barrier;

    logic            e_ready, e_b1, e_b2, e_b3, e_err;
    logic [3*RW-1:0] e_regnum;
    logic [IW-1:0]   e_instr;
    logic [15:0]     e_cnt;
    logic [15:0]     exp_q[$];   // {target is core 2, register_num}

    function automatic bit busy(input logic [RW-1:0] r);
        return (r != 0) && (reg_table[r] == 1'b1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_live = 1;
            inflight = 0; booted = 0;
            e_ready = 1; e_b1 = 0; e_b2 = 0; e_b3 = 0; e_err = 0;
            e_regnum = '0; e_instr = '0; e_cnt = '0;
            exp_q.delete();
        end else if (model_live) begin
            bit hz;
            e_b1 = 0; e_b2 = 0; e_b3 = 0;
            if (!inflight) begin
                if (instr_valid) begin
                    m_data = instr_data; m_dst = instr_dst; m_src = instr_src;
                    m_multi = instr_multi; m_barrier = instr_barrier;
                    inflight = 1; booted = 0;
                end
            end else if (m_barrier) begin
                if (sync_proc && processor_idle_1 && processor_idle_2) inflight = 0;
            end else if (!booted) begin
                hz = busy(m_src[4:0]) || busy(m_src[9:5]) || busy(m_dst[4:0]) ||
                     (m_multi && (busy(m_dst[9:5]) || busy(m_dst[14:10])));
                tgt = 0;
                if (!hz) begin
                    if (m_multi) tgt = processor_idle_2 ? 2 : 0;
                    else if (processor_idle_1) tgt = 1;
                    else if (processor_idle_2) tgt = 2;
                end
                if (tgt != 0) begin
                    booted = 1; t_boot = cyc;
                    e_b1 = (tgt == 1);
                    e_b2 = (tgt == 2) && !m_multi;
                    e_b3 = (tgt == 2) && m_multi;
                    e_regnum = m_multi ? m_dst : {10'd0, m_dst[4:0]};
                    e_instr = m_data;
                    e_cnt = e_cnt + 16'd1;
                    exp_q.push_back({tgt == 2, e_regnum});
                end
            end else begin
                if (!((tgt == 1) ? processor_idle_1 : processor_idle_2)) inflight = 0;
                else if (cyc - t_boot >= AT) begin
                    e_err = 1; inflight = 0;
                end
            end
            e_ready = !inflight;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (model_live && !rst) begin
            chk("instr_ready", instr_ready, e_ready);
            chk("boot_reg_1", boot_renew_register_1, e_b1);
            chk("boot_reg_2", boot_renew_register_2, e_b2);
            chk("boot_3reg_1", boot_renew_3registers_1, 1'b0);
            chk("boot_3reg_2", boot_renew_3registers_2, e_b3);
            chk("core_start_1", core_start_1, e_b1);
            chk("core_start_2", core_start_2, e_b2 | e_b3);
            chk("register_num", register_num, e_regnum);
            chk("core_instr", core_instr, e_instr);
            chk("dispatch_error", dispatch_error, e_err);
            chk("issued_count", issued_count, e_cnt);
            if (core_start_1 || core_start_2) begin
                chk("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("sb_boot", {core_start_2, register_num}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one instruction and returns after the accepting edge (+1).
    task automatic send(input logic [IW-1:0] d, input logic [3*RW-1:0] dst,
                        input logic [2*RW-1:0] src, input logic m, input logic b);
        int n = 0;
        @(negedge clk);
        instr_data = d; instr_dst = dst; instr_src = src;
        instr_multi = m; instr_barrier = b; instr_valid = 1'b1;
        while (!instr_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", instr_ready, 1'b1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", instr_ready, 1'b1);
    endtask

    function automatic logic any_boot();
        return boot_renew_register_1 | boot_renew_register_2 | boot_renew_3registers_2;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit seen;
        bit will_accept;
        int k;

        do_reset();

        // Reset values
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_boot", any_boot(), 1'b0);
        chk("rst_count", issued_count, 16'd0);
        chk("rst_regnum", register_num, 15'd0);

        // T1: single add, d1=5, s={4,3}, table clear, both idle -> core 1 at N+2
        send(32'hA0, {5'd0, 5'd0, 5'd5}, {5'd4, 5'd3}, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_no_boot_n1", any_boot(), 1'b0);
        @(negedge clk);
        chk("t1_boot1", boot_renew_register_1, 1'b1);
        chk("t1_start1", core_start_1, 1'b1);
        chk("t1_regnum", register_num, 15'd5);
        chk("t1_instr", core_instr, 32'hA0);
        wait_ready(50);

        // T2: table bit 4 busy, cleared after 6 cycles -> boot one cycle later
        reg_table[4] = 1'b1;
        send(32'hB1, {5'd0, 5'd0, 5'd9}, {5'd4, 5'd2}, 1'b0, 1'b0);
        seen = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (any_boot()) seen = 1;
        end
        chk("t2_held", seen, 1'b0);
        reg_table[4] = 1'b0;
        @(negedge clk);
        chk("t2_boot", any_boot(), 1'b1);
        chk("t2_regnum", register_num, 15'd9);
        wait_ready(50);
        repeat (8) @(negedge clk);   // let emulated cores go idle

        // T3: multi d={7,6,5}, core 2 not idle for a while
        force_2 = 1'b0;
        send(32'hC2, {5'd7, 5'd6, 5'd5}, {5'd9, 5'd8}, 1'b1, 1'b0);
        seen = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (any_boot()) seen = 1;
        end
        chk("t3_held", seen, 1'b0);
        force_2 = 1'b1;
        @(negedge clk);
        chk("t3_boot3_2", boot_renew_3registers_2, 1'b1);
        chk("t3_single_2", boot_renew_register_2, 1'b0);
        chk("t3_regnum", register_num, 15'h1CC5);
        wait_ready(50);
        repeat (8) @(negedge clk);

        // T4: core 1 busy, core 2 idle -> single goes to core 2
        force_1 = 1'b0;
        send(32'hD3, {5'd0, 5'd0, 5'd12}, {5'd1, 5'd2}, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t4_boot2", boot_renew_register_2, 1'b1);
        chk("t4_start2", core_start_2, 1'b1);
        chk("t4_boot1", boot_renew_register_1, 1'b0);
        @(negedge clk);
        chk("t4_start2_width", core_start_2, 1'b0);
        wait_ready(50);
        force_1 = 1'b1;
        repeat (8) @(negedge clk);

        // T5: target never acknowledges -> error after ACK_TIMEOUT cycles of waiting
        emu_en = 1'b0;
        send(32'hE4, {5'd0, 5'd0, 5'd3}, {5'd0, 5'd0}, 1'b0, 1'b0);
        k = 0;
        seen = 0;
        while (!seen && k < AT + 20) begin
            @(negedge clk);
            k++;
            if (dispatch_error) seen = 1;
        end
        chk("t5_error", seen, 1'b1);
        chk("t5_error_time", k, AT + 2);
        chk("t5_ready", instr_ready, 1'b1);
        emu_en = 1'b1;

        // T6: barrier with sync low for 10 cycles, then dispatch resumes
        sync_proc = 1'b0;
        send(32'hF5, '0, '0, 1'b0, 1'b1);
        seen = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (any_boot() || instr_ready) seen = 1;
        end
        chk("t6_held", seen, 1'b0);
        sync_proc = 1'b1;
        @(negedge clk);
        chk("t6_ready", instr_ready, 1'b1);
        chk("t6_count", issued_count, 16'd5);
        send(32'h16, {5'd0, 5'd0, 5'd2}, {5'd0, 5'd0}, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_resume_boot", boot_renew_register_1, 1'b1);
        chk("t6_count_after", issued_count, 16'd6);
        chk("t6_error_sticky", dispatch_error, 1'b1);
        wait_ready(50);

        // T7: reset mid-operation drops the pending instruction
        reg_table[4] = 1'b1;
        send(32'h27, {5'd0, 5'd0, 5'd4}, {5'd0, 5'd0}, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        do_reset();
        reg_table[4] = 1'b0;
        chk("t7_ready", instr_ready, 1'b1);
        chk("t7_count", issued_count, 16'd0);
        chk("t7_error", dispatch_error, 1'b0);
        repeat (4) @(negedge clk);
        chk("t7_no_boot", any_boot(), 1'b0);

        // Randomized phase
        will_accept = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            if (will_accept) instr_valid = 1'b0;
            if (!instr_valid && $urandom_range(0, 2) == 0) begin
                instr_data    = $urandom;
                instr_dst     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
                instr_src     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
                instr_multi   = ($urandom_range(0, 3) == 0);
                instr_barrier = ($urandom_range(0, 9) == 0);
                instr_valid   = 1'b1;
            end
            will_accept = instr_valid && instr_ready && !rst;
            reg_table = '0;
            if ($urandom_range(0, 2) == 0) reg_table[$urandom_range(0, 7)] = 1'b1;
            force_1   = ($urandom_range(0, 9) != 0);
            force_2   = ($urandom_range(0, 9) != 0);
            sync_proc = ($urandom_range(0, 1) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        instr_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
